// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared opcodes, producer latencies and flush-mask bit positions
package pipeline_hazard_ctrl_pkg;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam int LAT_ALU = 0;
   localparam int LAT_LOAD = 1;
   localparam int FLUSH_IFID = 0;
   localparam int FLUSH_IDEX = 1;
endpackage

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// hazard_scoreboard: per-register countdown until a pending result can be forwarded
module hazard_scoreboard #(
   parameter int NREGS = 32,
   parameter int LAT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue,
   input  logic [4:0]       rd,
   input  logic [LAT_W-1:0] lat,
   input  logic             hold,
   input  logic [LAT_W-1:0] thr,
   input  logic             rs1_used,
   input  logic [4:0]       rs1,
   input  logic             rs2_used,
   input  logic [4:0]       rs2,
   output logic             rs1_hit,
   output logic             rs2_hit,
   output logic             busy
);
   logic [LAT_W-1:0] cnt [NREGS];
   logic [LAT_W-1:0] lat_sat;
   assign lat_sat = &lat ? lat : lat + 1'b1;
   // x0 is never written, so cnt[0] stays at its reset value of zero
   always_ff @(posedge clk or posedge rst)
      if (rst) for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
      else for (int r = 1; r < NREGS; r++)
         if (issue && rd == 5'(r)) cnt[r] <= lat_sat;
         else if (!hold && cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
   assign rs1_hit = rs1_used && rs1 != '0 && cnt[rs1] > thr;
   assign rs2_hit = rs2_used && rs2 != '0 && cnt[rs2] > thr;
   always_comb begin
      busy = 1'b0;
      for (int r = 1; r < NREGS; r++) busy = busy || cnt[r] != '0;
   end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: scoreboard-driven stall/flush arbitration for the ID stage,
// with perf counters and a sticky stall watchdog.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int NUM_STAGES   = 5,
   parameter int NREGS        = 32,
   parameter int LAT_W        = 4,
   parameter int BRANCH_IN_ID = 1,
   parameter int PERF_W       = 32,
   parameter int TIMEOUT      = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [4:0]            id_rs1,
   input  logic [4:0]            id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic                  id_is_branch,
   input  logic [4:0]            id_rd,
   input  logic                  id_reg_write,
   input  logic [LAT_W-1:0]      id_lat,
   input  logic                  ex_is_branch,
   input  logic                  branch_mispredict,
   input  logic                  branch_redirect_id,
   input  logic                  inst_mem_wait,
   input  logic                  data_mem_wait,
   output logic                  hazard_stall,
   output logic                  mem_stall,
   output logic [NUM_STAGES-1:0] flush_mask,
   output logic                  id_issue,
   output logic                  sb_busy,
   output logic                  stall_timeout,
   output logic [PERF_W-1:0]     perf_stall_cycles,
   output logic [PERF_W-1:0]     perf_flushes
);
   localparam int RUN_W = $clog2(TIMEOUT + 1);
   logic rs1_hit, rs2_hit, jflush;
   logic [LAT_W-1:0] thr;
   logic [RUN_W-1:0] run;
   // an ID-resolved branch needs its operand a cycle earlier than an EX consumer
   assign thr = (BRANCH_IN_ID != 0 && id_is_branch) ? '0 : LAT_W'(1);
   hazard_scoreboard #(.NREGS(NREGS), .LAT_W(LAT_W)) u_sb (
      .clk(clk), .rst(rst),
      .issue(id_issue && id_reg_write), .rd(id_rd), .lat(id_lat),
      .hold(mem_stall), .thr(thr),
      .rs1_used(id_rs1_used), .rs1(id_rs1),
      .rs2_used(id_rs2_used), .rs2(id_rs2),
      .rs1_hit(rs1_hit), .rs2_hit(rs2_hit), .busy(sb_busy)
   );
   assign hazard_stall = id_valid && (rs1_hit || rs2_hit);
   assign mem_stall = inst_mem_wait || data_mem_wait;
   assign jflush = branch_mispredict && !ex_is_branch;
   always_comb begin
      flush_mask = '0;
      flush_mask[FLUSH_IFID] = jflush || (BRANCH_IN_ID != 0 ? branch_redirect_id && !hazard_stall
                                                            : branch_mispredict && ex_is_branch);
      flush_mask[FLUSH_IDEX] = jflush || (BRANCH_IN_ID == 0 && branch_mispredict && ex_is_branch);
   end
   assign id_issue = id_valid && !hazard_stall && !mem_stall && !flush_mask[FLUSH_IDEX];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         perf_stall_cycles <= '0;
         perf_flushes <= '0;
         run <= '0;
         stall_timeout <= 1'b0;
      end else begin
         if (!mem_stall) begin
            perf_stall_cycles <= perf_stall_cycles + PERF_W'(hazard_stall);
            perf_flushes <= perf_flushes + PERF_W'(|flush_mask);
         end
         run <= !hazard_stall ? '0 : run == RUN_W'(TIMEOUT) ? run : run + 1'b1;
         if (hazard_stall && run == RUN_W'(TIMEOUT - 1)) stall_timeout <= 1'b1;
      end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: checks an ID-branch and an EX-branch instance against a
// remaining-cycles reference model under directed and random stimulus.
module tb_pipeline_hazard_ctrl;
   import pipeline_hazard_ctrl_pkg::*;
   localparam int TMO = 64;
   logic clk = 1'b0, rst;
   logic id_valid, id_rs1_used, id_rs2_used, id_is_branch, id_reg_write;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic [3:0] id_lat;
   logic ex_is_branch, branch_mispredict, branch_redirect_id, inst_mem_wait, data_mem_wait;
   logic [1:0] hs, ms, iss, busy, to;
   logic [4:0] fm [2];
   logic [31:0] pst [2], pfl [2];
   int total = 0, bad = 0;
   int rem [2][32];
   int m_pst [2], m_pfl [2], m_run [2];
   bit m_to [2], e_hs [2], e_iss [2], e_busy [2], e_ms;
   logic [4:0] e_fm [2];

   always #5 clk = ~clk;

   // index 1: branches resolve in ID, index 0: branches resolve in EX
   for (genvar g = 0; g < 2; g++) begin : g_dut
      pipeline_hazard_ctrl #(.BRANCH_IN_ID(g)) dut (
         .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
         .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_is_branch(id_is_branch),
         .id_rd(id_rd), .id_reg_write(id_reg_write), .id_lat(id_lat),
         .ex_is_branch(ex_is_branch), .branch_mispredict(branch_mispredict),
         .branch_redirect_id(branch_redirect_id), .inst_mem_wait(inst_mem_wait),
         .data_mem_wait(data_mem_wait), .hazard_stall(hs[g]), .mem_stall(ms[g]),
         .flush_mask(fm[g]), .id_issue(iss[g]), .sb_busy(busy[g]), .stall_timeout(to[g]),
         .perf_stall_cycles(pst[g]), .perf_flushes(pfl[g]));
   end

   function automatic logic [9:0] got(int k);
      return {hs[k], ms[k], fm[k], iss[k], busy[k], to[k]};
   endfunction
   function automatic logic [9:0] expv(int k);
      return {e_hs[k], e_ms, e_fm[k], e_iss[k], e_busy[k], m_to[k]};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < 32; r++) rem[k][r] = 0;
         m_pst[k] = 0; m_pfl[k] = 0; m_run[k] = 0; m_to[k] = 0;
      end
   endtask

   task automatic eval();
      e_ms = inst_mem_wait || data_mem_wait;
      for (int k = 0; k < 2; k++) begin
         int thr = (k == 1 && id_is_branch) ? 0 : 1;
         bit jf = branch_mispredict && !ex_is_branch;
         e_hs[k] = id_valid && ((id_rs1_used && id_rs1 != 0 && rem[k][id_rs1] > thr) ||
                                (id_rs2_used && id_rs2 != 0 && rem[k][id_rs2] > thr));
         e_fm[k] = jf ? 5'b00011 : (k == 1 && branch_redirect_id && !e_hs[k]) ? 5'b00001 :
                   (k == 0 && branch_mispredict) ? 5'b00011 : 5'b00000;
         e_iss[k] = id_valid && !e_hs[k] && !e_ms && !e_fm[k][1];
         e_busy[k] = 0;
         for (int r = 0; r < 32; r++) if (rem[k][r] > 0) e_busy[k] = 1;
      end
   endtask

   task automatic update();
      for (int k = 0; k < 2; k++) begin
         if (!e_ms) begin
            for (int r = 0; r < 32; r++) if (rem[k][r] > 0) rem[k][r]--;
            m_pst[k] += int'(e_hs[k]);
            m_pfl[k] += int'(e_fm[k] != 0);
         end
         if (e_iss[k] && id_reg_write && id_rd != 0) rem[k][id_rd] = (id_lat + 1 > 15) ? 15 : id_lat + 1;
         m_run[k] = e_hs[k] ? m_run[k] + 1 : 0;
         if (m_run[k] >= TMO) m_to[k] = 1;
      end
   endtask

   task automatic settle();
      eval();
      @(negedge clk);
   endtask
   task automatic tick();
      @(posedge clk);
      update();
      #1;
   endtask

   task automatic idle();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0; id_is_branch = 0;
      id_rd = 0; id_reg_write = 0; id_lat = 0; ex_is_branch = 0; branch_mispredict = 0;
      branch_redirect_id = 0; inst_mem_wait = 0; data_mem_wait = 0;
   endtask
   task automatic produce(input int rd, input int lat);
      idle();
      id_valid = 1; id_rd = 5'(rd); id_reg_write = 1; id_lat = 4'(lat);
   endtask
   task automatic consume(input int rs, input bit br);
      idle();
      id_valid = 1; id_rs1 = 5'(rs); id_rs1_used = 1; id_rs2 = br ? 5'd0 : 5'd1; id_rs2_used = 1;
      id_is_branch = br;
   endtask

   task automatic test_reset();
      idle();
      settle();
      for (int k = 0; k < 2; k++) begin
         total++;
         if (got(k) !== 10'b0 || pst[k] !== 0 || pfl[k] !== 0) begin
            bad++; $display("FAIL reset k=%0d got=%b perf=%0d/%0d exp all zero", k, got(k), pst[k], pfl[k]);
         end
      end
      tick();
   endtask

   task automatic test_latencies();
      int rd_t [5] = '{5, 3, 5, 7, 7};
      int lat_t [5] = '{LAT_LOAD, LAT_ALU, LAT_LOAD, 4, 4};
      int gap_t [5] = '{0, 0, 1, 0, 0};
      bit br_t [5] = '{0, 1, 1, 0, 0};
      bit mem_t [5] = '{0, 0, 0, 0, 1};
      int e1_t [5] = '{1, 1, 1, 4, 6};
      int e0_t [5] = '{1, 0, 0, 4, 6};
      for (int s = 0; s < 5; s++) begin
         int st [2] = '{0, 0};
         idle();
         repeat (20) tick();
         produce(rd_t[s], lat_t[s]);
         settle();
         tick();
         idle();
         repeat (gap_t[s]) begin settle(); tick(); end
         for (int c = 0; c < 12; c++) begin
            consume(rd_t[s], br_t[s]);
            inst_mem_wait = mem_t[s] && (c == 1 || c == 2);
            settle();
            for (int k = 0; k < 2; k++) begin
               st[k] += int'(hs[k]);
               total++;
               if (got(k) !== expv(k)) begin
                  bad++; $display("FAIL lat s=%0d c=%0d k=%0d got=%b exp=%b", s, c, k, got(k), expv(k));
               end
            end
            tick();
         end
         total++;
         if (st[1] !== e1_t[s] || st[0] !== e0_t[s]) begin
            bad++; $display("FAIL stall_count s=%0d got=%0d/%0d exp=%0d/%0d", s, st[1], st[0], e1_t[s], e0_t[s]);
         end
      end
   endtask

   task automatic test_flush();
      idle();
      repeat (20) tick();
      produce(9, 3);
      branch_mispredict = 1; branch_redirect_id = 1;
      settle();
      for (int k = 0; k < 2; k++) begin
         total++;
         if (fm[k] !== 5'b00011 || iss[k] !== 1'b0 || got(k) !== expv(k)) begin
            bad++; $display("FAIL jflush k=%0d got=%b exp=%b", k, got(k), expv(k));
         end
      end
      tick();
      consume(9, 0);
      settle();
      total++;
      if (hs !== 2'b00 || busy !== 2'b00) begin
         bad++; $display("FAIL flushed_no_write got hs=%b busy=%b exp 00/00", hs, busy);
      end
      tick();
      idle();
      branch_mispredict = 1; ex_is_branch = 1;
      settle();
      total++;
      if (fm[0] !== 5'b00011 || fm[1] !== 5'b00000) begin
         bad++; $display("FAIL ex_branch got=%b/%b exp=00011/00000", fm[0], fm[1]);
      end
      tick();
      produce(4, 3);
      settle(); tick();
      consume(4, 0);
      branch_redirect_id = 1;
      for (int c = 0; c < 4; c++) begin
         settle();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (got(k) !== expv(k) || pfl[k] !== 32'(m_pfl[k])) begin
               bad++; $display("FAIL redirect c=%0d k=%0d got=%b exp=%b pfl=%0d exp=%0d", c, k, got(k), expv(k), pfl[k], m_pfl[k]);
            end
         end
         tick();
      end
   endtask

   task automatic test_saturate_reset();
      int st = 0;
      idle();
      repeat (20) tick();
      produce(10, 15);
      settle(); tick();
      consume(10, 0);
      for (int c = 0; c < 20; c++) begin settle(); st += int'(hs[1]); tick(); end
      total++;
      if (st !== 14) begin bad++; $display("FAIL saturate stalls got=%0d exp=14", st); end
      produce(0, 15);
      settle(); tick();
      idle();
      settle();
      total++;
      if (busy !== 2'b00 || e_busy[1]) begin bad++; $display("FAIL rd0_tracked got busy=%b exp=00", busy); end
      tick();
      produce(11, 10);
      settle(); tick();
      consume(11, 0);
      settle();
      total++;
      if (hs !== 2'b11) begin bad++; $display("FAIL pre_reset hs got=%b exp=11", hs); end
      #2 rst = 1;
      #1 model_reset();
      eval();
      total++;
      if (busy !== 2'b00 || hs !== 2'b00 || pst[1] !== 0) begin
         bad++; $display("FAIL mid_reset got busy=%b hs=%b pst=%0d exp 00/00/0", busy, hs, pst[1]);
      end
      @(negedge clk) rst = 0;
      tick();
   endtask

   task automatic test_timeout();
      rst = 1; #1 model_reset();
      @(negedge clk) rst = 0;
      tick();
      produce(12, 15);
      settle(); tick();
      consume(12, 0);
      for (int c = 0; c < 90; c++) begin
         data_mem_wait = (c >= 5 && c < 65);
         settle();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (got(k) !== expv(k) || pst[k] !== 32'(m_pst[k])) begin
               bad++; $display("FAIL timeout c=%0d k=%0d got=%b exp=%b pst=%0d exp=%0d", c, k, got(k), expv(k), pst[k], m_pst[k]);
            end
         end
         tick();
      end
      total++;
      if (to !== 2'b11) begin bad++; $display("FAIL timeout_sticky got=%b exp=11", to); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         id_valid = $urandom_range(0, 9) < 8;
         id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
         id_rs1_used = $urandom_range(0, 3) != 0; id_rs2_used = $urandom_range(0, 1) == 1;
         id_is_branch = $urandom_range(0, 3) == 0;
         id_rd = 5'($urandom_range(0, 7)); id_reg_write = $urandom_range(0, 3) != 0;
         id_lat = $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
         ex_is_branch = $urandom_range(0, 1) == 1;
         branch_mispredict = $urandom_range(0, 9) == 0;
         branch_redirect_id = $urandom_range(0, 9) == 0;
         inst_mem_wait = $urandom_range(0, 15) == 0; data_mem_wait = $urandom_range(0, 15) == 0;
         settle();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (got(k) !== expv(k) || pst[k] !== 32'(m_pst[k]) || pfl[k] !== 32'(m_pfl[k])) begin
               bad++; $display("FAIL random c=%0d k=%0d got=%b exp=%b pst=%0d/%0d pfl=%0d/%0d", c, k, got(k), expv(k), pst[k], m_pst[k], pfl[k], m_pfl[k]);
            end
         end
         tick();
      end
   endtask

   initial begin
      rst = 1;
      idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 0;
      test_reset();
      test_latencies();
      test_flush();
      test_saturate_reset();
      test_timeout();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
